// File: rtl/obf_key_loader.sv
// rtl/obf_key_loader.sv - bit-serial key loader that holds a decoy key on a locked netlist until a full key is loaded.
// Optional trailing even-parity check is compiled in with OBF_KEY_LOADER_PARITY_EN.
module obf_key_loader #(
  parameter int                KEY_W     = 32,
  parameter logic [KEY_W-1:0]  DECOY_KEY = {KEY_W{1'b0}}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_start_i,
  input  logic             key_bit_i,
  input  logic             key_valid_i,
  output logic             key_ready_o,
  output logic [KEY_W-1:0] keyinput_o,
  output logic             key_valid_o,
  output logic             load_done_o,
  output logic             load_err_o
);

  localparam int CNT_W = $clog2(KEY_W) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef OBF_KEY_LOADER_PARITY_EN
  localparam logic [1:0] S_PAR   = 2'd2;
`endif
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [KEY_W-1:0] shreg;
  logic             last_bit;

`ifdef OBF_KEY_LOADER_PARITY_EN
  logic             fail;
  logic             err_q;
  assign key_ready_o = (state == S_SHIFT) || (state == S_PAR);
  assign load_err_o  = err_q;
`else
  assign key_ready_o = (state == S_SHIFT);
  assign load_err_o  = 1'b0;
`endif

  assign last_bit = (cnt == CNT_W'(KEY_W - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      keyinput_o  <= DECOY_KEY;
      key_valid_o <= 1'b0;
      load_done_o <= 1'b0;
`ifdef OBF_KEY_LOADER_PARITY_EN
      fail        <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      load_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_start_i) begin
            state <= S_SHIFT;
            cnt   <= '0;
            shreg <= '0;
`ifdef OBF_KEY_LOADER_PARITY_EN
            fail  <= 1'b0;
            err_q <= 1'b0;
`endif
          end
        end
        S_SHIFT: begin
          // A restart pulse wins over a bit presented in the same cycle.
          if (load_start_i) begin
            cnt   <= '0;
            shreg <= '0;
`ifdef OBF_KEY_LOADER_PARITY_EN
            err_q <= 1'b0;
`endif
          end else if (key_valid_i) begin
            shreg <= {shreg[KEY_W-2:0], key_bit_i};
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
`ifdef OBF_KEY_LOADER_PARITY_EN
              state <= S_PAR;
`else
              state       <= S_DONE;
              load_done_o <= 1'b1;
`endif
            end
          end
        end
`ifdef OBF_KEY_LOADER_PARITY_EN
        S_PAR: begin
          if (load_start_i) begin
            state <= S_SHIFT;
            cnt   <= '0;
            shreg <= '0;
            err_q <= 1'b0;
          end else if (key_valid_i) begin
            // Even parity: key bits plus the parity bit must XOR to zero.
            fail        <= ^{shreg, key_bit_i};
            state       <= S_DONE;
            load_done_o <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
`ifdef OBF_KEY_LOADER_PARITY_EN
          if (fail) begin
            keyinput_o  <= DECOY_KEY;
            key_valid_o <= 1'b0;
            err_q       <= 1'b1;
          end else begin
            keyinput_o  <= shreg;
            key_valid_o <= 1'b1;
          end
`else
          keyinput_o  <= shreg;
          key_valid_o <= 1'b1;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obf_key_loader.sv
// tb/tb_obf_key_loader.sv - scoreboard bench for obf_key_loader; follows OBF_KEY_LOADER_PARITY_EN if defined.
module tb_obf_key_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        load_start_i = 1'b0;
  logic        key_bit_i = 1'b0;
  logic        key_valid_i = 1'b0;
  logic        key_ready_o;
  logic [31:0] keyinput_o;
  logic        key_valid_o;
  logic        load_done_o;
  logic        load_err_o;

  obf_key_loader #(.KEY_W(32), .DECOY_KEY(32'h0)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_start_i (load_start_i),
    .key_bit_i    (key_bit_i),
    .key_valid_i  (key_valid_i),
    .key_ready_o  (key_ready_o),
    .keyinput_o   (keyinput_o),
    .key_valid_o  (key_valid_o),
    .load_done_o  (load_done_o),
    .load_err_o   (load_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] key;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  logic [31:0] cur_key = 32'h0;
  logic        cur_valid = 1'b0;
  logic        prev_done = 1'b0;

`ifdef OBF_KEY_LOADER_PARITY_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Locked adder stand-in: only the correct key cancels the operand scrambling.
  function automatic logic [16:0] locked_add(input logic [15:0] a, input logic [15:0] b,
                                             input logic [31:0] k);
    return {1'b0, a ^ k[31:16] ^ 16'h00B8} + {1'b0, b ^ k[15:0] ^ 16'h9E0F};
  endfunction

  // Reference model: what a finished load should leave on the outputs.
  function automatic exp_t model(input logic [31:0] key, input logic p);
    exp_t e;
    logic pass;
    pass = !PARITY || ((($countones(key) + int'(p)) % 2) == 0);
    e.key   = pass ? key : 32'h0;
    e.valid = pass;
    e.err   = !pass;
    return e;
  endfunction

  // Monitor: commit values appear one cycle after the load_done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_done = 1'b0;
      end else begin
        if (prev_done) begin
          if (q.size() == 0) begin
            check("unexpected_done", 64'(load_done_o), 64'(1'b0));
          end else begin
            e = q.pop_front();
            check("commit_key", 64'(keyinput_o), 64'(e.key));
            check("commit_valid", 64'(key_valid_o), 64'(e.valid));
            check("commit_err", 64'(load_err_o), 64'(e.err));
            cur_key   = e.key;
            cur_valid = e.valid;
          end
        end else begin
          check("hold_key", 64'(keyinput_o), 64'(cur_key));
          check("hold_valid", 64'(key_valid_o), 64'(cur_valid));
        end
        if (load_done_o) done_cnt++;
        prev_done = load_done_o;
      end
    end
  end

  task automatic start_load();
    @(negedge clk_i);
    key_valid_i = 1'b1;
    key_bit_i   = 1'($urandom_range(0, 1));
    @(negedge clk_i);
    done_cnt     = 0;
    load_start_i = 1'b1;
    key_valid_i  = 1'($urandom_range(0, 1));
    key_bit_i    = 1'b1;
    @(negedge clk_i);
    load_start_i = 1'b0;
    key_valid_i  = 1'b0;
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    while (gaps && $urandom_range(0, 2) == 0) begin
      key_valid_i = 1'b0;
      key_bit_i   = 1'($urandom_range(0, 1));
      @(negedge clk_i);
    end
    check("ready_in_load", 64'(key_ready_o), 64'(1'b1));
    key_valid_i = 1'b1;
    key_bit_i   = b;
    @(negedge clk_i);
    key_valid_i = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] key, input logic p, input bit gaps);
    start_load();
    q.push_back(model(key, p));
    for (int i = 31; i >= 0; i--) send_bit(key[i], gaps);
    if (PARITY) send_bit(p, gaps);
    repeat (4) @(negedge clk_i);
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("ready_idle", 64'(key_ready_o), 64'(1'b0));
  endtask

  function automatic logic even_par(input logic [31:0] k);
    return 1'(^k);
  endfunction

  initial begin
    logic [31:0] k;
    #1;
    check("rst_key", 64'(keyinput_o), 64'h0);
    check("rst_valid", 64'(key_valid_o), 64'(1'b0));
    check("rst_ready", 64'(key_ready_o), 64'(1'b0));
    check("rst_done", 64'(load_done_o), 64'(1'b0));
    check("rst_err", 64'(load_err_o), 64'(1'b0));
    #22 rst_ni = 1'b1;

    do_load(32'h00B89E0F, 1'b1, 1'b0);
    check("adder", 64'(locked_add(16'h29AF, 16'h7A1B, keyinput_o)), 64'h0A3CA);

    do_load(32'h00B89E0F, 1'b0, 1'b0);

    start_load();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    do_load(32'hDEADBEEF, 1'b0, 1'b0);

    do_load(32'h00B89E0F, 1'b1, 1'b1);
    do_load(32'h12345678, even_par(32'h12345678), 1'b0);

    for (int n = 0; n < 6; n++) begin
      k = $urandom;
      do_load(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    start_load();
    for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_key", 64'(keyinput_o), 64'h0);
    check("async_rst_valid", 64'(key_valid_o), 64'(1'b0));
    check("async_rst_ready", 64'(key_ready_o), 64'(1'b0));
    cur_key   = 32'h0;
    cur_valid = 1'b0;
    q.delete();
    #11 rst_ni = 1'b1;

    do_load(32'hDEADBEEF, 1'b0, 1'b1);

    check("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/obf_key_loader.md
# obf_key_loader

Serial key-provisioning block that sits in front of an XOR-locked netlist and drives its `keyinput` bus. It accepts a key bit-serially over a valid/ready handshake from secure storage or a test host. It holds a decoy key on the locked netlist until a complete key has been received and, when the parity feature is compiled in, verified. It then presents the key and flags it valid until reset or the next load.

## Interface
Parameters:
- KEY_W, 32, key width in bits; must be ≥ 2.
- DECOY_KEY, {KEY_W{1'b0}}, value driven on `keyinput_o` whenever no verified key is held.

Ports:
- clk_i  in  1  sole clock; all state updates on its rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- load_start_i  in  1  one-cycle pulse that begins a key load.
- key_bit_i  in  1  serial key data, MSB first.
- key_valid_i  in  1  `key_bit_i` valid this cycle.
- key_ready_o  out  1  loader accepts a bit this cycle.
- keyinput_o  out  KEY_W  key bus to the locked netlist.
- key_valid_o  out  1  `keyinput_o` holds a verified loaded key.
- load_done_o  out  1  one-cycle pulse when a load finishes, pass or fail.
- load_err_o  out  1  sticky parity-failure flag; cleared by reset or `load_start_i`.

## Operation
- States: IDLE, SHIFT, PAR (only when the parity feature is compiled in), DONE.
- IDLE: `key_ready_o`=0. When `load_start_i`=1, go to SHIFT, clear the bit counter and shift register, and clear `load_err_o`.
- SHIFT: `key_ready_o`=1. A bit is accepted on each edge where `key_valid_i`=1, as `shreg <= {shreg[KEY_W-2:0], key_bit_i}`, and the counter increments.
  - On acceptance of bit KEY_W-1, go to PAR if the parity feature is compiled in, otherwise go to DONE.
  - The counter is $clog2(KEY_W)+1 bits wide and never wraps.
- PAR: `key_ready_o`=1. On an accepted bit p, compare p to the even parity of `shreg`, i.e. XOR of all key bits XOR p must equal 0. Go to DONE.
- DONE, pass (one cycle): `keyinput_o`<=shreg, `key_valid_o`<=1, `load_done_o`=1, then go to IDLE.
- DONE, fail (one cycle): `keyinput_o`<=DECOY_KEY, `key_valid_o`<=0, `load_err_o`<=1, `load_done_o`=1, then go to IDLE.
- During a load (SHIFT/PAR), `keyinput_o` and `key_valid_o` keep their previous values. The partial key is never visible on `keyinput_o`.
- Boundary cases:
  - `load_start_i` in SHIFT or PAR: abort the current load, restart SHIFT with the counter at 0, and keep outputs unchanged.
  - `load_start_i` in DONE: ignored.
  - `load_start_i` and `key_valid_i` in the same IDLE cycle: the bit is not accepted, because `key_ready_o` was 0.
  - `key_valid_i` in IDLE or DONE: ignored.
  - Reset mid-load: all state returns to reset values immediately; the partial key is lost.

## Timing
- Reset values: state=IDLE, `keyinput_o`=DECOY_KEY, `key_valid_o`=0, `key_ready_o`=0, `load_done_o`=0, `load_err_o`=0, shift register=0.
- All outputs are registered except `key_ready_o`, which decodes from the state register.
- Load latency: `load_start_i` at edge 0, then KEY_W (+1 with parity) accepted bits. `keyinput_o`/`key_valid_o` update on the edge after DONE is entered.
- Minimum full load: KEY_W+3 cycles with parity, KEY_W+2 without.
- Back-to-back bits are allowed with no gap cycles. Stalls (`key_valid_i`=0) hold all state.

## Configuration
- Macro: `OBF_KEY_LOADER_PARITY_EN`.
- Defined: PAR state exists, one trailing even-parity bit is required, and a mismatch drives DECOY_KEY and sets `load_err_o`.
- Undefined: no PAR state, every completed load passes, and `load_err_o` is tied to 0.

## Test plan
- Reset check: assert `rst_ni`=0 mid-simulation → `keyinput_o`=DECOY_KEY (32'h0), `key_valid_o`=0, `key_ready_o`=0, asynchronously without waiting for a clock edge.
- Good load (parity on): start, then bits of 32'h00B89E0F MSB first, then parity bit 1 → `keyinput_o`=32'h00B89E0F and `key_valid_o`=1 one cycle after `load_done_o`. Drive the locked adder with 0x29AF+0x7A1B → result 17'h0A3CA.
- Bad parity: same key with parity bit 0 → `keyinput_o`=32'h0, `key_valid_o`=0, `load_err_o`=1, `load_done_o` pulses once.
- Abort/restart: `load_start_i` after 10 bits, then a full good load of 32'hDEADBEEF (parity 0) → `keyinput_o`=32'hDEADBEEF. The previous key stays on `keyinput_o` throughout the load.
- Stalls: random `key_valid_i` gaps during a load of 32'h00B89E0F → same final result as the gap-free load, and the bit count is unaffected.
- Parity off (macro undefined): 32 bits of 32'h12345678, no parity bit → `key_valid_o`=1 after KEY_W+2 cycles, `load_err_o` stays 0.
